// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the TX arbiter state encoding.
package uart_pkg;

  localparam int PAYLOAD_BITS = 8;

  typedef enum logic [2:0] {
    ARB,
    ACCEPT,
    LAUNCH,
    SETTLE,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx launch/busy handshake.
// The arbiter is the slave of this bus; requesters and uart_tx form the master side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ        = 2,
  parameter int PAYLOAD_BITS = uart_pkg::PAYLOAD_BITS
);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [N_REQ-1:0]              req_last;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0]              grant;
  logic                          uart_tx_en;
  logic [PAYLOAD_BITS-1:0]       uart_tx_data;
  logic                          uart_tx_busy;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, grant, uart_tx_en, uart_tx_data
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, grant, uart_tx_en, uart_tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot first requester at or after ptr, with wrap.
// Zero latency; found is low and pick is zero when nobody requests.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             found
);

  always_comb begin
    logic [PTR_W-1:0] sel;
    pick  = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[sel]) begin
        pick[sel] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte streams, round-robin with packet locking.
// First valid to uart_tx_en is 2 cycles; requesters wait on req_ready, which only the owner sees in ACCEPT.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int PAYLOAD_BITS = uart_pkg::PAYLOAD_BITS
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t              state_q, state_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    last_q, last_d;

  logic [N_REQ-1:0]        pick;
  logic                    found;
  logic [PTR_W-1:0]        pick_idx;
  logic                    sel_valid;
  logic                    sel_last;
  logic [PAYLOAD_BITS-1:0] sel_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .pick  (pick),
    .found (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  // Only the owner's lane is looked at; other requesters are invisible while a packet is open.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = bus.req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_last = bus.req_last[i];
      end
    end
  end

  assign sel_valid = |(bus.req_valid & grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (found) state_d = ACCEPT;
      ACCEPT:  if (sel_valid) state_d = LAUNCH;
      LAUNCH:  if (!bus.uart_tx_busy) state_d = SETTLE;
      // busy is not yet valid for the byte just launched
      SETTLE:  state_d = DRAIN;
      DRAIN:   if (!bus.uart_tx_busy) state_d = last_q ? ARB : ACCEPT;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    bus.uart_tx_en   = (state_q == LAUNCH);
    bus.req_ready    = (state_q == ACCEPT) ? grant_q : '0;
    bus.grant        = grant_q;
    bus.uart_tx_data = data_q;
  end

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      ARB: begin
        if (found) begin
          grant_d = pick;
          ptr_d   = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
        end
      end
      ACCEPT: begin
        if (sel_valid) begin
          data_d = sel_data;
          last_d = sel_last;
        end
      end
      DRAIN: begin
        if (!bus.uart_tx_busy && last_q) grant_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing cases on a 2-requester instance and
// randomized packet traffic on a 3-requester instance against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(2)) if2 ();
  uart_tx_arbiter_if #(.N_REQ(3)) if3 ();

  uart_tx_arbiter #(.N_REQ(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx_arbiter #(.N_REQ(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  // each queue entry is {last, byte}
  logic [8:0] q2 [2][$];
  logic [8:0] q3 [3][$];
  logic [7:0] log2 [$];
  logic [9:0] log3 [$];
  logic [7:0] exp2 [$];
  logic [9:0] exp3 [$];

  int   frame2 = 4;
  int   cnt2   = 0;
  int   cnt3   = 0;
  int   gap2   = 0;
  int   gap3   = 0;
  logic force_busy2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [2:0] g);
    if (g == 3'b001) return 2'd0;
    if (g == 3'b010) return 2'd1;
    if (g == 3'b100) return 2'd2;
    return 2'd3;
  endfunction

  // uart_tx stand-ins: busy rises the cycle after an accepted launch
  assign if2.uart_tx_busy = force_busy2 || (cnt2 != 0);
  assign if3.uart_tx_busy = (cnt3 != 0);

  always @(posedge clk) begin
    if (if2.uart_tx_en && !if2.uart_tx_busy) begin
      cnt2 <= frame2;
      log2.push_back(if2.uart_tx_data);
    end else if (cnt2 > 0) begin
      cnt2 <= cnt2 - 1;
    end
  end

  always @(posedge clk) begin
    if (if3.uart_tx_en && !if3.uart_tx_busy) begin
      cnt3 <= int'($urandom_range(1, 8));
      log3.push_back({oh2idx(if3.grant), if3.uart_tx_data});
    end else if (cnt3 > 0) begin
      cnt3 <= cnt3 - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && (((if2.req_ready & ~if2.grant) != 0) || (if2.uart_tx_en && if2.req_ready != 0) ||
                 ((if3.req_ready & ~if3.grant) != 0) || (if3.uart_tx_en && if3.req_ready != 0)))
      viol <= viol + 1;
  end

  // Requester sources: present the queue head; only bytes after the first of a packet may be gapped.
  initial begin : drv2
    logic [1:0]  acc, mid, v, l;
    logic [15:0] d;
    mid = '0;
    if2.req_valid = '0; if2.req_data = '0; if2.req_last = '0;
    forever begin
      @(negedge clk);
      acc = if2.req_valid & if2.req_ready;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      if (rst) mid = '0;
      else for (int r = 0; r < 2; r++) begin
        if (acc[r] && q2[r].size() > 0) begin
          mid[r] = !q2[r][0][8];
          void'(q2[r].pop_front());
        end
        if (q2[r].size() > 0 && !(mid[r] && int'($urandom_range(0, 99)) < gap2)) begin
          v[r] = 1'b1; l[r] = q2[r][0][8]; d[r*8 +: 8] = q2[r][0][7:0];
        end
      end
      if2.req_valid = v; if2.req_last = l; if2.req_data = d;
    end
  end

  initial begin : drv3
    logic [2:0]  acc, mid, v, l;
    logic [23:0] d;
    mid = '0;
    if3.req_valid = '0; if3.req_data = '0; if3.req_last = '0;
    forever begin
      @(negedge clk);
      acc = if3.req_valid & if3.req_ready;
      @(posedge clk);
      #1;
      v = '0; l = '0; d = '0;
      if (rst) mid = '0;
      else for (int r = 0; r < 3; r++) begin
        if (acc[r] && q3[r].size() > 0) begin
          mid[r] = !q3[r][0][8];
          void'(q3[r].pop_front());
        end
        if (q3[r].size() > 0 && !(mid[r] && int'($urandom_range(0, 99)) < gap3)) begin
          v[r] = 1'b1; l[r] = q3[r][0][8]; d[r*8 +: 8] = q3[r][0][7:0];
        end
      end
      if3.req_valid = v; if3.req_last = l; if3.req_data = d;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    force_busy2 = 1'b0;
    for (int r = 0; r < 2; r++) q2[r].delete();
    for (int r = 0; r < 3; r++) q3[r].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100 && (if2.uart_tx_busy || if3.uart_tx_busy); i++) @(negedge clk);
    log2.delete();
    log3.delete();
  endtask

  task automatic wait_log2(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (log2.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (log2.size() < n) chk({tag, "_timeout"}, log2.size(), n);
  endtask

  task automatic cmp_log2(input string tag);
    chk({tag, "_count"}, log2.size(), exp2.size());
    for (int i = 0; i < exp2.size() && i < log2.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), log2[i], exp2[i]);
  endtask

  task automatic test_single();
    do_reset();
    frame2 = 20;
    @(posedge clk);
    q2[0].push_back({1'b1, 8'h41});
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      case (c)
        0:  begin chk("single_c0_grant", if2.grant, 0); chk("single_c0_ready", if2.req_ready, 0); end
        1:  begin chk("single_c1_grant", if2.grant, 1); chk("single_c1_ready", if2.req_ready, 1);
                  chk("single_c1_en", if2.uart_tx_en, 0); end
        2:  begin chk("single_c2_en", if2.uart_tx_en, 1); chk("single_c2_data", if2.uart_tx_data, 8'h41);
                  chk("single_c2_ready", if2.req_ready, 0); end
        23: chk("single_c23_grant", if2.grant, 1);
        24: chk("single_c24_grant", if2.grant, 0);
        default: ;
      endcase
    end
    exp2 = '{8'h41};
    cmp_log2("single");
  endtask

  task automatic test_simul();
    do_reset();
    frame2 = int'($urandom_range(2, 6));
    @(posedge clk);
    // both requesters keep requesting: two packets each, queued from the start
    q2[0].push_back({1'b1, 8'h30}); q2[0].push_back({1'b1, 8'h30});
    q2[1].push_back({1'b1, 8'h31}); q2[1].push_back({1'b1, 8'h31});
    wait_log2(4, 400, "simul");
    exp2 = '{8'h30, 8'h31, 8'h30, 8'h31};
    cmp_log2("simul");
  endtask

  task automatic test_lock();
    int early;
    do_reset();
    frame2 = int'($urandom_range(2, 10));
    gap2 = 40;
    early = 0;
    @(posedge clk);
    q2[0].push_back({1'b0, 8'h61}); q2[0].push_back({1'b0, 8'h62}); q2[0].push_back({1'b1, 8'h63});
    @(posedge clk);
    q2[1].push_back({1'b1, 8'h7A});
    for (int c = 0; c < 600 && log2.size() < 4; c++) begin
      @(negedge clk);
      if (if2.req_ready[1] && log2.size() < 3) early++;
    end
    gap2 = 0;
    chk("lock_r1_ready_early", early, 0);
    exp2 = '{8'h61, 8'h62, 8'h63, 8'h7A};
    cmp_log2("lock");
  endtask

  task automatic test_busy();
    int c;
    do_reset();
    frame2 = 5;
    force_busy2 = 1'b1;
    @(posedge clk);
    q2[0].push_back({1'b0, 8'h5A}); q2[0].push_back({1'b1, 8'hA5});
    c = 0;
    while (!if2.uart_tx_en && c < 20) begin @(negedge clk); c++; end
    chk("busy_en_seen", if2.uart_tx_en, 1);
    repeat (5) begin
      @(negedge clk);
      chk("busy_en_held", if2.uart_tx_en, 1);
    end
    chk("busy_no_launch", log2.size(), 0);
    force_busy2 = 1'b0;
    @(negedge clk);
    chk("busy_en_drop", if2.uart_tx_en, 0);
    chk("busy_one_launch", log2.size(), 1);
    wait_log2(2, 100, "busy");
    repeat (30) @(negedge clk);
    exp2 = '{8'h5A, 8'hA5};
    cmp_log2("busy");
  endtask

  task automatic test_reset();
    do_reset();
    frame2 = 10;
    @(posedge clk);
    q2[0].push_back({1'b0, 8'h71}); q2[0].push_back({1'b0, 8'h72}); q2[0].push_back({1'b1, 8'h73});
    wait_log2(2, 200, "rst_pre");
    @(negedge clk);
    chk("rst_pre_grant", if2.grant, 1);
    rst = 1'b1;
    #1;
    chk("rst_grant", if2.grant, 0);
    chk("rst_ready", if2.req_ready, 0);
    chk("rst_en", if2.uart_tx_en, 0);
    chk("rst_data", if2.uart_tx_data, 0);
    for (int r = 0; r < 2; r++) q2[r].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log2.delete();
    @(posedge clk);
    q2[1].push_back({1'b1, 8'h7B});
    @(negedge clk);
    chk("rst_after_c0_grant", if2.grant, 0);
    @(negedge clk);
    chk("rst_after_c1_grant", if2.grant, 2'b10);
    @(posedge clk);
    q2[0].push_back({1'b1, 8'h7C});
    wait_log2(2, 200, "rst_after");
    exp2 = '{8'h7B, 8'h7C};
    cmp_log2("rst_after");
  endtask

  task automatic test_fair();
    logic [8:0] m [3][$];
    int ptr;
    do_reset();
    gap3 = 30;
    exp3.delete();
    @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 6; p++) begin
        int len;
        len = (p < 2) ? 1 : int'($urandom_range(1, 3));
        for (int b = 0; b < len; b++) begin
          logic [8:0] e;
          e = {(b == len - 1), 8'($urandom_range(0, 255))};
          q3[r].push_back(e);
          m[r].push_back(e);
        end
      end
    end
    // reference: whole packets, next owner is the first non-empty source after the last one
    ptr = 0;
    while (m[0].size() + m[1].size() + m[2].size() > 0) begin
      int         w;
      logic [8:0] e;
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && m[(ptr + k) % 3].size() > 0) w = (ptr + k) % 3;
      do begin
        e = m[w].pop_front();
        exp3.push_back({2'(w), e[7:0]});
      end while (!e[8]);
      ptr = (w + 1) % 3;
    end
    for (int c = 0; c < 5000 && log3.size() < exp3.size(); c++) @(negedge clk);
    gap3 = 0;
    chk("fair_count", log3.size(), exp3.size());
    for (int i = 0; i < exp3.size() && i < log3.size(); i++)
      chk($sformatf("fair_tx%0d", i), log3[i], exp3[i]);
    for (int i = 0; i < 6 && i < log3.size(); i++)
      chk($sformatf("fair_grant%0d", i), log3[i][9:8], i % 3);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_grant2", if2.grant, 0);
    chk("reset_ready2", if2.req_ready, 0);
    chk("reset_en2", if2.uart_tx_en, 0);
    chk("reset_data2", if2.uart_tx_data, 0);
    chk("reset_grant3", if3.grant, 0);
    chk("reset_en3", if3.uart_tx_en, 0);
    rst = 1'b0;
    test_single();
    test_simul();
    test_lock();
    test_busy();
    test_reset();
    test_fair();
    chk("ready_en_invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
